mux2t1_5: RTL and testbench
===========================

// Module: mux2t1_5
// PURPOSE
// - 2-to-1 word multiplexer, 5 bits by default: o = s ? I1 : I0.
// - Combinational path with zero latency. Used as the select stage in the datapath
//   muxctrl experiments, e.g. register-address and write-data selection.
// - Also provides a registered copy of the output and of the select, plus a
//   select-change pulse, for downstream clocked logic.
// PARAMETERS
// - WIDTH    5   data width of I0, I1, o, o_q
// - RST_VAL  0   value loaded into o_q on reset (WIDTH bits)
// PORTS
// - clk   in   1      single system clock; all state updates on its rising edge
// - rst   in   1      asynchronous, active-high reset; clears registered state only
// - I0    in   WIDTH  data input selected when s=0
// - I1    in   WIDTH  data input selected when s=1
// - s     in   1      select
// - o     out  WIDTH  combinational mux output
// - o_q   out  WIDTH  o registered on clk
// - s_q   out  1      s registered on clk
// - sw    out  1      one-cycle pulse; high when s differs from s_q at the last edge
// BEHAVIOUR
// - o = s ? I1 : I0, purely combinational.
//   - o updates in the same delta as any change on I0, I1 or s.
//   - o has no dependence on clk or rst. It is valid even if clk never toggles
//     and rst is left undriven.
// - Width rule: all data paths are exactly WIDTH bits, with no extension or truncation.
// - Registered state (o_q, s_q, sw):
//   - While rst=1 (asynchronous, immediate): o_q=RST_VAL, s_q=0, sw=0.
//   - At each rising clk edge with rst=0: o_q<=o, s_q<=s, sw<=(s!=s_q).
//   - Latency is 1 cycle from a change on I0, I1 or s to o_q.
//   - sw is high for exactly one cycle per change of the sampled select.
// - Reset asserted mid-operation: registered outputs clear at once, without
//   waiting for a clock edge. o continues to follow its inputs.
// - Reset release: the first rising edge samples normally. If s=1 at that edge,
//   sw=1 because s_q was 0.
// - Simultaneous input and select change: o reflects the new select with the
//   new data. o_q samples whatever o is at the edge.
// - No handshake and no FSM.
// STRUCTURE
// - Shared package: DATA_W=5 and the reset-value constant, shared with the other
//   muxctrl blocks.
// - One natural sub-module: dff_ar, a parameterised-width D flip-flop with
//   asynchronous active-high reset and reset value.
//   - Instantiated for o_q, s_q and sw.
//   - The mux itself is a single continuous assignment in the top module.
// TESTING
// - Combinational select, clk idle, rst low.
//   - I0=5'd0, I1=5'd1, s=0 -> o=5'd0.
//   - After 50 ns, s=0 -> o stays 5'd0.
//   - After 50 ns, s=1 -> o=5'd1 in the same timestep.
// - Full-width data: I0=5'h1F, I1=5'h0A.
//   - s=0 -> o=5'h1F; s=1 -> o=5'h0A.
//   - Change I1 to 5'h15 while s=1 -> o=5'h15 immediately.
// - Registered path:
//   - Hold s=1, I1=5'h0A; one rising edge -> o_q=5'h0A, s_q=1.
//   - Before that edge, o_q still holds its prior value.
// - Select-change pulse:
//   - Toggle s 0->1 -> sw=1 for exactly one cycle after the next edge.
//   - Holding s -> sw=0 on following edges.
// - Async reset mid-operation:
//   - Assert rst between clock edges -> o_q=RST_VAL(0), s_q=0, sw=0 with no
//     clock edge, while o still equals I0 or I1 per s.
//   - Release rst -> normal sampling resumes at the next edge.

Source files
------------

// File: rtl/mux2t1_5_pkg.sv
// ---------------------------------------------------------------------------
// mux2t1_5_pkg
// Purpose : Shared constants for the muxctrl select-stage blocks.
//           DATA_W      - default word width of the select stage
//           MUX_RST_VAL - value a registered mux output takes while reset is held
//           mux_sel()   - reference select function, usable by any muxctrl block
// ---------------------------------------------------------------------------
package mux2t1_5_pkg;

   localparam int DATA_W      = 5;
   localparam int MUX_RST_VAL = 0;

   // Two-way word select, kept here so the muxctrl blocks share one definition
   // of which input corresponds to which select value.
   function automatic logic [DATA_W-1:0] mux_sel(
      input logic              sel,
      input logic [DATA_W-1:0] a0,
      input logic [DATA_W-1:0] a1
   );
      return sel ? a1 : a0;
   endfunction

endpackage

// File: rtl/mux2t1_5_dff_ar.sv
// ---------------------------------------------------------------------------
// mux2t1_5_dff_ar
// Purpose : Parameterised-width D flip-flop with asynchronous active-high
//           reset to a programmable value.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset, loads RST_VAL immediately
//           i_d  - data input (W bits)
//           o_q  - registered output (W bits)
// ---------------------------------------------------------------------------
module mux2t1_5_dff_ar #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= RST_VAL;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/mux2t1_5.sv
// ---------------------------------------------------------------------------
// mux2t1_5
// Purpose : 2-to-1 word multiplexer (o = s ? I1 : I0) with a registered copy
//           of the output and of the select, plus a one-cycle pulse whenever
//           the sampled select changes.
// Ports   : clk  in  1      system clock, rising edge
//           rst  in  1      asynchronous active-high reset (registered state only)
//           I0   in  WIDTH  data selected when s=0
//           I1   in  WIDTH  data selected when s=1
//           s    in  1      select
//           o    out WIDTH  combinational mux output, zero latency
//           o_q  out WIDTH  o registered on clk
//           s_q  out 1      s registered on clk
//           sw   out 1      high for one cycle when s differed from s_q at the last edge
// ---------------------------------------------------------------------------
module mux2t1_5
   import mux2t1_5_pkg::*;
#(
   parameter int               WIDTH   = DATA_W,
   parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(MUX_RST_VAL)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic             s,
   output logic [WIDTH-1:0] o,
   output logic [WIDTH-1:0] o_q,
   output logic             s_q,
   output logic             sw
);

   logic w_sw_d;

   // The mux path is independent of clk and rst so it stays valid with an
   // idle clock or a floating reset.
   assign o = s ? I1 : I0;

   // Compare against the already-registered select so the pulse marks the
   // edge at which the new select value is first captured.
   assign w_sw_d = (s != s_q);

   mux2t1_5_dff_ar #(
      .W       (WIDTH),
      .RST_VAL (RST_VAL)
   ) u_dff_o (
      .clk (clk),
      .rst (rst),
      .i_d (o),
      .o_q (o_q)
   );

   mux2t1_5_dff_ar #(
      .W       (1),
      .RST_VAL (1'b0)
   ) u_dff_s (
      .clk (clk),
      .rst (rst),
      .i_d (s),
      .o_q (s_q)
   );

   mux2t1_5_dff_ar #(
      .W       (1),
      .RST_VAL (1'b0)
   ) u_dff_sw (
      .clk (clk),
      .rst (rst),
      .i_d (w_sw_d),
      .o_q (sw)
   );

endmodule

// File: tb/tb_mux2t1_5.sv
// ---------------------------------------------------------------------------
// tb_mux2t1_5
// Purpose : Self-checking bench for mux2t1_5. Combinational results are
//           compared directly; registered results go through a scoreboard
//           queue filled when stimulus is driven and drained after the edge.
// ---------------------------------------------------------------------------
module tb_mux2t1_5;

   localparam int W = 5;

   typedef struct {
      logic [W-1:0] oq;
      logic         sq;
      logic         sw;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [W-1:0] I0;
   logic [W-1:0] I1;
   logic         s;
   logic [W-1:0] o;
   logic [W-1:0] o_q;
   logic         s_q;
   logic         sw;

   logic         clk_en;
   logic         model_sq;
   int           n_cmp;
   int           n_err;
   exp_t         sb_q[$];

   mux2t1_5 dut (
      .clk (clk),
      .rst (rst),
      .I0  (I0),
      .I1  (I1),
      .s   (s),
      .o   (o),
      .o_q (o_q),
      .s_q (s_q),
      .sw  (sw)
   );

   initial clk = 1'b0;
   always #5 if (clk_en) clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, wanted %0h", tag, obs, exp);
      end
   endtask

   // Drive one transaction, push the registered result it must produce,
   // then wait one edge and pop/compare.
   task automatic step(input logic [W-1:0] a0, input logic [W-1:0] a1, input logic sel);
      exp_t e;
      exp_t g;
      I0 = a0;
      I1 = a1;
      s  = sel;
      #1;
      check("o_comb", 32'(o), 32'(sel ? a1 : a0));
      e.oq = sel ? a1 : a0;
      e.sq = sel;
      e.sw = (sel != model_sq);
      model_sq = sel;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_empty: got 0 entries, wanted 1");
      end else begin
         g = sb_q.pop_front();
         $display("txn I0=%02h I1=%02h s=%0d -> o_q=%02h s_q=%0d sw=%0d (exp %02h %0d %0d)",
                  a0, a1, sel, o_q, s_q, sw, g.oq, g.sq, g.sw);
         check("o_q", 32'(o_q), 32'(g.oq));
         check("s_q", 32'(s_q), 32'(g.sq));
         check("sw",  32'(sw),  32'(g.sw));
      end
      @(negedge clk);
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      clk_en   = 1'b0;
      model_sq = 1'b0;
      I0 = '0;
      I1 = '0;
      s  = 1'b0;

      // Reset with no clock: registered state clears immediately.
      rst = 1'b1;
      #1;
      check("rst_o_q", 32'(o_q), 32'd0);
      check("rst_s_q", 32'(s_q), 32'd0);
      check("rst_sw",  32'(sw),  32'd0);
      rst = 1'b0;

      // Combinational select with the clock idle.
      I0 = 5'd0; I1 = 5'd1; s = 1'b0;
      #1;  check("comb_s0", 32'(o), 32'd0);
      #50; check("comb_hold", 32'(o), 32'd0);
      s = 1'b1;
      #1;  check("comb_s1", 32'(o), 32'd1);

      // Full-width data.
      I0 = 5'h1F; I1 = 5'h0A; s = 1'b0;
      #1; check("fw_s0", 32'(o), 32'h1F);
      s = 1'b1;
      #1; check("fw_s1", 32'(o), 32'h0A);
      I1 = 5'h15;
      #1; check("fw_i1chg", 32'(o), 32'h15);
      I1 = 5'h0A;
      #1;
      // No edge yet: o_q still holds the reset value.
      check("oq_pre_edge", 32'(o_q), 32'd0);

      // Registered path and select-change pulse.
      clk_en = 1'b1;
      step(5'h1F, 5'h0A, 1'b1);   // first edge: s_q was 0 -> sw=1
      step(5'h1F, 5'h0A, 1'b1);   // held -> sw=0
      step(5'h03, 5'h0C, 1'b0);
      step(5'h03, 5'h0C, 1'b0);
      step(5'h07, 5'h18, 1'b1);
      step(5'h11, 5'h0E, 1'b0);
      step(5'h11, 5'h0E, 1'b1);
      step(5'h11, 5'h0E, 1'b1);

      // Async reset between edges (we are at a negedge here).
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_o_q", 32'(o_q), 32'd0);
      check("mid_rst_s_q", 32'(s_q), 32'd0);
      check("mid_rst_sw",  32'(sw),  32'd0);
      check("mid_rst_o",   32'(o),   32'(5'h0E));
      model_sq = 1'b0;
      @(posedge clk);
      #1;
      check("rst_hold_o_q", 32'(o_q), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Release: first edge samples normally, s=1 gives sw=1.
      step(5'h02, 5'h1D, 1'b1);
      step(5'h02, 5'h1D, 1'b1);
      step(5'h1B, 5'h04, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
